// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master controller and its SCK generator.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } state_t;

  localparam int RW_BIT      = 7;
  localparam int FRAME_LEN   = 16;
  localparam int SPI_MODE    = 3;
  localparam int INIT_CYCLES = 2;

  // CPOL follows from the mode number: modes 2 and 3 idle high.
  localparam logic SCK_IDLE = (SPI_MODE >= 2) ? 1'b1 : 1'b0;

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period counter producing a registered SCK plus strobes that flag the
// clock edge at which SCK is about to fall or rise.
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic fall_stb,
  output logic rise_stb
);

  logic [7:0] half_cnt;
  logic       toggle;

  assign toggle   = en && (half_cnt == 8'(HALF - 1));
  assign fall_stb = toggle && (sck == SCK_IDLE);
  assign rise_stb = toggle && (sck != SCK_IDLE);

  // Disabled means parked at the idle level with the counter cleared, so the
  // first toggle after enable lands exactly HALF cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_cnt <= '0;
      sck      <= SCK_IDLE;
    end else if (!en) begin
      half_cnt <= '0;
      sck      <= SCK_IDLE;
    end else if (toggle) begin
      half_cnt <= '0;
      sck      <= ~sck;
    end else begin
      half_cnt <= half_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-3 master that runs single 16-bit register read/write frames to the
// slave memory and arbitrates the slave's mem_initial strobe against commands.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              init_req,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              SS,
  output logic              SCK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              mem_initial
);

  localparam int FRAME_W = 2 * DATA_W;

  state_t              state, next_state;
  logic                rdy_en;
  logic [7:0]          wait_cnt;
  logic [4:0]          rise_cnt;
  logic [FRAME_W-1:0]  tx_sr;
  logic [DATA_W-1:0]   rx_sr;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   cmd_byte;
  logic                rw_q;
  logic                idle_ok, accept, in_frame, tail, sck_en;
  logic                fall_stb, rise_stb;

  assign idle_ok   = (state == ST_IDLE) && rdy_en;
  assign cmd_ready = idle_ok && !init_req;
  assign accept    = cmd_valid && cmd_ready;
  assign in_frame  = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);
  // After the last rising edge SCK stays high for the rest of the frame.
  assign tail      = (rise_cnt == 5'(FRAME_LEN));
  // Running the generator through SETUP makes its first toggle the first fall.
  assign sck_en    = ((state == ST_SETUP) || (state == ST_SHIFT)) && !tail;

  assign SS          = !in_frame;
  assign MOSI        = in_frame && tx_sr[FRAME_W-1];
  assign mem_initial = (state == ST_INIT);
  assign rsp_valid   = (state == ST_DONE);
  assign rsp_rdata   = rdata_q;

  spi_sck_gen #(
    .HALF(CLK_DIV)
  ) u_sck_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (sck_en),
    .sck     (SCK),
    .fall_stb(fall_stb),
    .rise_stb(rise_stb)
  );

  always_comb begin
    cmd_byte                = '0;
    cmd_byte[RW_BIT]        = cmd_rw;
    cmd_byte[ADDR_W-1:0]    = cmd_addr;
  end

  // Holds cmd_ready low through reset and releases it on the first clock after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en <= 1'b0;
    else     rdy_en <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (idle_ok && init_req)       next_state = ST_INIT;
        else if (idle_ok && cmd_valid) next_state = ST_SETUP;
      end
      ST_INIT:  if (wait_cnt == 8'(INIT_CYCLES - 1)) next_state = ST_IDLE;
      ST_SETUP: if (fall_stb) next_state = ST_SHIFT;
      ST_SHIFT: if (tail && (wait_cnt == 8'(CLK_DIV - 1))) next_state = ST_HOLD;
      ST_HOLD:  if (wait_cnt == 8'(CLK_DIV - 1)) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (next_state != state) begin
      wait_cnt <= '0;
    end else if ((state == ST_INIT) || (state == ST_HOLD) || ((state == ST_SHIFT) && tail)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // The first bit is already on MOSI at accept, so only later falls shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sr    <= '0;
      rx_sr    <= '0;
      rw_q     <= 1'b0;
      rise_cnt <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        tx_sr    <= {cmd_byte, (cmd_rw ? {DATA_W{1'b0}} : cmd_wdata)};
        rx_sr    <= '0;
        rw_q     <= cmd_rw;
        rise_cnt <= '0;
      end else if (state == ST_SHIFT) begin
        if (fall_stb) tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
        if (rise_stb) begin
          rx_sr    <= {rx_sr[DATA_W-2:0], MISO};
          rise_cnt <= rise_cnt + 5'd1;
        end
      end
      if ((state == ST_HOLD) && (next_state == ST_DONE)) begin
        rdata_q <= rw_q ? rx_sr : '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: a behavioural SPI slave with its own
// memory, queued expectations from a reference memory, and frame timing monitors.
module tb_spi_master_ctrl;

  localparam int H      = 4;
  localparam int LAT    = 1 + 34 * H;
  localparam int SS_LOW = 34 * H;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_rw = 1'b0;
  logic [3:0] cmd_addr = 4'h0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       init_req = 1'b0;
  logic       MISO = 1'b0;
  logic       cmd_ready, rsp_valid, SS, SCK, MOSI, mem_initial;
  logic [7:0] rsp_rdata;

  spi_master_ctrl #(
    .CLK_DIV(H),
    .ADDR_W (4),
    .DATA_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_rw     (cmd_rw),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .init_req   (init_req),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .SS         (SS),
    .SCK        (SCK),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .mem_initial(mem_initial)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  ref_mem [16];
  logic [7:0]  slave_mem [16];
  logic [7:0]  exp_rdata_q [$];
  logic [15:0] exp_frame_q [$];
  int          acc_q [$];
  int          s_rises = 0;

  function automatic logic [7:0] seed_byte(input int i);
    if (i == 3) return 8'h5C;
    return 8'((i * 37) + 11);
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: actual=timeout/none expected=event", name);
  endtask

  // Issues one command; tracked commands push their expected frame and response.
  task automatic apply_stimulus(input bit rw, input logic [3:0] addr, input logic [7:0] wdata,
                                input bit keep_valid, input bit track);
    bit got = 0;
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    if (track) begin
      exp_rdata_q.push_back(rw ? ref_mem[addr] : 8'h00);
      exp_frame_q.push_back({rw, 3'b000, addr, (rw ? 8'h00 : wdata)});
      if (!rw) ref_mem[addr] = wdata;
    end
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready) got = 1;
    end
    if (!got) flag_fail("accept_timeout");
    @(posedge clk);
    #1;
    if (!keep_valid) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && exp_rdata_q.size() != 0; i++) @(posedge clk);
    if (exp_rdata_q.size() != 0) flag_fail("response_timeout");
    @(posedge clk);
    #1;
  endtask

  // Behavioural mode-3 slave: samples MOSI on SCK rise, drives MISO after SCK fall.
  initial begin : slave
    logic [15:0] sh;
    logic [7:0]  scmd;
    logic [7:0]  b;
    int          nf;
    logic        p_sck, p_ss;
    for (int i = 0; i < 16; i++) slave_mem[i] = seed_byte(i);
    sh = '0; scmd = '0; nf = 0; p_sck = 1'b1; p_ss = 1'b1;
    forever begin
      @(SCK or SS);
      if (p_ss === 1'b1 && SS === 1'b0) begin
        s_rises = 0; nf = 0; sh = '0; scmd = '0;
      end
      if (SS === 1'b0 && !rst && p_sck === 1'b0 && SCK === 1'b1) begin
        sh = {sh[14:0], MOSI};
        s_rises++;
        if (s_rises == 8) scmd = sh[7:0];
      end
      if (SS === 1'b0 && p_sck === 1'b1 && SCK === 1'b0) begin
        nf++;
        if (nf >= 9 && scmd[7]) begin
          b = slave_mem[scmd[3:0]];
          MISO = b[16 - nf];
        end else begin
          MISO = 1'($urandom);
        end
      end
      if (p_ss === 1'b0 && SS === 1'b1 && !rst && s_rises == 16) begin
        if (exp_frame_q.size() == 0) flag_fail("unexpected_frame");
        else check_output("mosi_frame", {16'h0, sh}, {16'h0, exp_frame_q.pop_front()});
        if (!sh[15]) slave_mem[sh[11:8]] = sh[7:0];
      end
      p_sck = SCK;
      p_ss  = SS;
    end
  end

  // Response scoreboard and frame/init timing monitor, sampled mid-cycle.
  logic p_ss_m = 1'b1, p_sck_m = 1'b1;
  int ss_low_cnt = 0, ss_high_cnt = 0, last_gap = 0, sck_r = 0, sck_f = 0;
  int init_cnt = 0, init_pulses = 0;

  always @(negedge clk) begin
    if (rst) begin
      ss_low_cnt = 0; ss_high_cnt = 0; sck_r = 0; sck_f = 0; init_cnt = 0;
      p_ss_m = 1'b1; p_sck_m = 1'b1;
    end else begin
      if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
      if (rsp_valid) begin
        if (exp_rdata_q.size() == 0) begin
          flag_fail("unexpected_rsp");
        end else begin
          check_output("rsp_rdata", {24'h0, rsp_rdata}, {24'h0, exp_rdata_q.pop_front()});
          if (acc_q.size() == 0) flag_fail("latency_no_accept");
          else check_output("latency", cyc - acc_q.pop_front(), LAT);
        end
      end
      if (!SS) begin
        if (p_ss_m) begin
          last_gap = ss_high_cnt; ss_low_cnt = 0; sck_r = 0; sck_f = 0;
        end
        ss_low_cnt++;
        if (SCK && !p_sck_m) sck_r++;
        if (!SCK && p_sck_m) sck_f++;
      end else begin
        if (!p_ss_m) begin
          check_output("ss_low_len", ss_low_cnt, SS_LOW);
          check_output("sck_rises", sck_r, 16);
          check_output("sck_falls", sck_f, 16);
          ss_high_cnt = 0;
        end
        ss_high_cnt++;
      end
      if (mem_initial) begin
        init_cnt++;
        check_output("ss_in_init", SS, 1);
      end else if (init_cnt != 0) begin
        check_output("init_len", init_cnt, 2);
        init_pulses++;
        init_cnt = 0;
      end
      p_ss_m  = SS;
      p_sck_m = SCK;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    bit         rw, keep;
    logic [3:0] addr;
    logic [7:0] wd;
    for (int i = 0; i < 16; i++) ref_mem[i] = seed_byte(i);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_cmd_ready", cmd_ready, 0);
    check_output("rst_rsp_valid", rsp_valid, 0);
    check_output("rst_rsp_rdata", rsp_rdata, 0);
    check_output("rst_ss", SS, 1);
    check_output("rst_sck", SCK, 1);
    check_output("rst_mosi", MOSI, 0);
    check_output("rst_mem_initial", mem_initial, 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_output("ready_after_reset", cmd_ready, 1);
    @(posedge clk);
    #1;

    $display("[TB] write F <- A5");
    apply_stimulus(1'b0, 4'hF, 8'hA5, 1'b0, 1'b1);
    wait_idle();

    $display("[TB] read 3");
    apply_stimulus(1'b1, 4'h3, 8'hFF, 1'b0, 1'b1);
    wait_idle();

    $display("[TB] init_req and command together");
    init_req = 1'b1;
    fork
      begin
        @(posedge clk);
        #1;
        init_req = 1'b0;
      end
    join_none
    apply_stimulus(1'b1, 4'h3, 8'h00, 1'b0, 1'b1);
    wait_idle();
    check_output("init_pulses", init_pulses, 1);

    $display("[TB] reset during write");
    apply_stimulus(1'b0, 4'h2, 8'h99, 1'b0, 1'b0);
    for (int i = 0; i < 1000 && s_rises < 6; i++) begin
      @(posedge clk);
      #1;
    end
    if (s_rises < 6) flag_fail("rise6_timeout");
    rst = 1'b1;
    #1;
    check_output("abort_ss", SS, 1);
    check_output("abort_sck", SCK, 1);
    check_output("abort_mosi", MOSI, 0);
    check_output("abort_rsp_valid", rsp_valid, 0);
    check_output("abort_rsp_rdata", rsp_rdata, 0);
    check_output("abort_cmd_ready", cmd_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    acc_q.delete();
    @(posedge clk);
    #1;
    apply_stimulus(1'b1, 4'h2, 8'h00, 1'b0, 1'b1);
    wait_idle();

    $display("[TB] back-to-back reads");
    apply_stimulus(1'b1, 4'h5, 8'h00, 1'b1, 1'b1);
    init_req = 1'b1;
    @(posedge clk);
    #1;
    init_req = 1'b0;
    apply_stimulus(1'b1, 4'hF, 8'h00, 1'b0, 1'b1);
    wait_idle();
    check_output("b2b_ss_gap", last_gap, 2);
    check_output("init_ignored_busy", init_pulses, 1);

    $display("[TB] random traffic");
    for (int n = 0; n < 24; n++) begin
      rw   = 1'($urandom_range(0, 1));
      addr = 4'($urandom_range(0, 15));
      wd   = 8'($urandom);
      keep = (n != 23) && ($urandom_range(0, 1) == 1);
      apply_stimulus(rw, addr, wd, keep, 1'b1);
      if (!keep) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    cmd_valid = 1'b0;
    wait_idle();
    repeat (4) @(posedge clk);
    check_output("frames_left", exp_frame_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
